// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one multiplier bit retired per clock,
// M-clock latency from accepted start to a one-cycle done pulse with a registered product.
module shift_add_multiplier #(
  parameter int N = 16,
  parameter int M = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     multiplicand,
  input  logic [M-1:0]     multiplier,
  output logic             busy,
  output logic             done,
  output logic [N+M-1:0]   product
);

  localparam int CW = $clog2(M + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [N+M:0]     acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N+M-1:0]   product_q, product_d;

  logic [N-1:0]     addend;
  logic [N:0]       sum;
  logic [N+M:0]     acc_shift;

  // 2:1 select feeding the adder; acc top bit is always zero so the carry slot
  // of the upper slice adds nothing and the carry of sum is preserved.
  always_comb begin
    addend    = acc_q[0] ? mcand_q : '0;
    sum       = acc_q[N+M:M] + {1'b0, addend};
    acc_shift = {1'b0, sum, acc_q[M-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = multiplicand;
          acc_d   = {1'b0, {N{1'b0}}, multiplier};
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        acc_d = acc_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(M - 1)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          product_d = acc_shift[N+M-1:0];
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: vector table, multi-cycle corner sequences and random pairs,
// with expected products queued at issue and compared when done pulses.
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product;

  shift_add_multiplier #(.N(16), .M(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NT = 8;
  vec_t        tbl [NT];
  logic [31:0] q [$];
  int          errors = 0;
  int          checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_product(input string name);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected done, got product 0x%0h, expected no result", name, product);
    end else begin
      check(name, product, q.pop_front());
    end
  endtask

  // Drive a start pulse; returns just after the accepting edge k.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called just after edge k; follows the operation through the done pulse.
  task automatic wait_done(input string tag);
    int lat;
    int bcnt;
    lat  = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 16);
    check({tag, " busy cycles"}, bcnt, 16);
    check({tag, " busy at done"}, busy, 0);
    check_product({tag, " product"});
    @(negedge clk);
    check({tag, " done one cycle"}, done, 0);
  endtask

  initial begin
    int          lat;
    int          seen;
    int          ndone;
    logic [15:0] pa [4];
    logic [15:0] pb [4];
    logic [15:0] ra;
    logic [15:0] rb;

    tbl[0] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    tbl[1] = '{16'h0003, 16'h0005, 32'h0000000F};
    tbl[2] = '{16'h1234, 16'h0000, 32'h00000000};
    tbl[3] = '{16'h0000, 16'hFFFF, 32'h00000000};
    tbl[4] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
    tbl[5] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
    tbl[6] = '{16'h8000, 16'h0002, 32'h00010000};
    tbl[7] = '{16'h8000, 16'h8000, 32'h40000000};

    rst_n        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;

    // Asynchronous reset with no clock edge yet.
    #2 rst_n = 1'b0;
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset product", product, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NT; i++) begin
      start_op(tbl[i].a, tbl[i].b, tbl[i].exp);
      wait_done($sformatf("vec%0d", i));
    end

    // Restarts at k+5 and during DONE are ignored; product holds during RUN.
    @(negedge clk);
    multiplicand = 16'd2;
    multiplier   = 16'd2;
    start        = 1'b1;
    q.push_back(32'd4);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    multiplicand = 16'd7;
    multiplier   = 16'd7;
    start        = 1'b1;
    check("ign product hold", product, tbl[NT-1].exp);
    lat = 4;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ign latency", lat, 16);
    check_product("ign product");
    @(negedge clk);
    start = 1'b0;
    check("ign done drop", done, 0);
    check("ign busy after done", busy, 0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("ign no second op", seen, 0);

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    multiplicand = 16'hFFFF;
    multiplier   = 16'hFFFF;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("abort no done", seen, 0);
    start_op(16'd10, 16'd10, 32'd100);
    wait_done("abort recover");

    // Start held high: accepts at k, k+18, k+36, k+54; operands change right after each accept.
    pa[0] = 16'd3;    pb[0] = 16'd5;
    pa[1] = 16'hFFFF; pb[1] = 16'hFFFF;
    pa[2] = 16'd100;  pb[2] = 16'd200;
    pa[3] = 16'h1234; pb[3] = 16'h5678;
    @(negedge clk);
    multiplicand = pa[0];
    multiplier   = pb[0];
    start        = 1'b1;
    q.push_back(32'(pa[0]) * 32'(pb[0]));
    ndone = 0;
    for (int cyc = 0; cyc <= 80; cyc++) begin
      @(negedge clk);
      if (cyc == 0 || cyc == 18 || cyc == 36) begin
        multiplicand = pa[cyc/18 + 1];
        multiplier   = pb[cyc/18 + 1];
        q.push_back(32'(pa[cyc/18 + 1]) * 32'(pb[cyc/18 + 1]));
      end
      if (cyc == 54) start = 1'b0;
      if (done === 1'b1) begin
        check($sformatf("b2b%0d done cycle", ndone), cyc, 16 + 18 * ndone);
        check($sformatf("b2b%0d busy at done", ndone), busy, 0);
        check_product($sformatf("b2b%0d product", ndone));
        ndone++;
      end
    end
    check("b2b op count", ndone, 4);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      start_op(ra, rb, 32'(ra) * 32'(rb));
      wait_done($sformatf("rand%0d", i));
    end

    check("scoreboard empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
